// File: rtl/lc3b_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_fetch_pkg
// Brief    : Shared PCMUX encodings, reset PC and queue entry type for fetch.
// Revision : 1.0
// ============================================================================
package lc3b_fetch_pkg;

    localparam logic [1:0] PCMUX_SEQ    = 2'b00;
    localparam logic [1:0] PCMUX_TARGET = 2'b01;
    localparam logic [1:0] PCMUX_TRAP   = 2'b10;

    localparam int          FETCH_WIDTH      = 16;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h3000;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0] npc;
        logic [FETCH_WIDTH-1:0] ir;
    } fetch_entry_t;

    // The reserved select code behaves exactly like sequential fetch.
    function automatic logic [1:0] pcmux_effective(input logic [1:0] sel);
        return (sel == 2'b11) ? PCMUX_SEQ : sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous FIFO with flush; zero data presented while empty.
// Revision : 1.0
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              w_do_wr;
    logic              w_do_rd;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign w_do_wr = wr_en && !full && !flush;
    assign w_do_rd = rd_en && !empty && !flush;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointers are exactly PTR_W bits wide, so increment wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (w_do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_queue
// Brief    : LC-3b instruction prefetch: fetch PC, memory request, entry queue.
//            Optional macro FETCH_PERF_CNT_EN enables saturating perf counters.
// Revision : 1.0
// ============================================================================
module prefetch_queue
    import lc3b_fetch_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             pcmux,
    input  logic [WIDTH-1:0]       target_pc,
    input  logic [WIDTH-1:0]       trap_pc,
    input  logic                   br_stall,
    output logic                   imem_req,
    output logic [WIDTH-1:0]       imem_addr,
    input  logic                   imem_r,
    input  logic [WIDTH-1:0]       imem_data,
    input  logic                   de_ready,
    output logic                   de_v,
    output logic [WIDTH-1:0]       de_ir,
    output logic [WIDTH-1:0]       de_npc,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic [15:0]            perf_fetched,
    output logic [15:0]            perf_stall,
    output logic [15:0]            perf_flush
);
    logic [WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [1:0]         w_pcmux_eff;
    logic               w_seq;
    logic               w_redirect;
    logic               w_accept;
    logic               w_deq;
    logic               w_empty;
    logic [WIDTH-1:0]   w_next_pc;
    logic [2*WIDTH-1:0] w_head;

    assign w_pcmux_eff = pcmux_effective(pcmux);
    assign w_seq       = (w_pcmux_eff == PCMUX_SEQ);
    assign w_redirect  = !w_seq;
    assign w_next_pc   = fetch_pc_q + WIDTH'(2);

    // A redirect cycle never requests, so redirect-cycle data is never enqueued.
    assign imem_req  = !full && !br_stall && w_seq && !rst;
    assign imem_addr = fetch_pc_q;
    assign w_accept  = imem_req && imem_r;

    assign de_v   = !w_empty && w_seq && !rst;
    assign de_npc = rst ? '0 : w_head[2*WIDTH-1:WIDTH];
    assign de_ir  = rst ? '0 : w_head[WIDTH-1:0];
    assign w_deq  = de_v && de_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (w_pcmux_eff == PCMUX_TARGET) begin
            fetch_pc_d = target_pc;
        end else if (w_pcmux_eff == PCMUX_TRAP) begin
            fetch_pc_d = trap_pc;
        end else if (w_accept) begin
            fetch_pc_d = w_next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) fetch_pc_q <= RESET_PC;
        else     fetch_pc_q <= fetch_pc_d;
    end

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (2*WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (w_redirect),
        .wr_en   (w_accept),
        .wr_data ({w_next_pc, imem_data}),
        .rd_en   (w_deq),
        .rd_data (w_head),
        .count   (count),
        .full    (full),
        .empty   (w_empty)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched_q, perf_fetched_d;
    logic [15:0] perf_stall_q,   perf_stall_d;
    logic [15:0] perf_flush_q,   perf_flush_d;

    // Counters saturate at all-ones rather than wrapping.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        perf_flush_d   = perf_flush_q;
        if (w_accept && perf_fetched_q != 16'hFFFF)
            perf_fetched_d = perf_fetched_q + 16'd1;
        if (de_ready && !de_v && perf_stall_q != 16'hFFFF)
            perf_stall_d = perf_stall_q + 16'd1;
        if (w_redirect && perf_flush_q != 16'hFFFF)
            perf_flush_d = perf_flush_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
            perf_flush_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
            perf_flush_q   <= perf_flush_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
    assign perf_flush   = perf_flush_q;
`else
    assign perf_fetched = '0;
    assign perf_stall   = '0;
    assign perf_flush   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_prefetch_queue
// Brief    : Directed table, stall sequence and random check against a queue model.
// Revision : 1.0
// ============================================================================
module tb_prefetch_queue;
    localparam int DEPTH = 4;
    localparam int WIDTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pcmux;
    logic [15:0] target_pc, trap_pc;
    logic        br_stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_r;
    logic [15:0] imem_data;
    logic        de_ready;
    logic        de_v;
    logic [15:0] de_ir, de_npc;
    logic [2:0]  count;
    logic        full;
    logic [15:0] perf_fetched, perf_stall, perf_flush;

    always #5 clk = ~clk;

    prefetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RESET_PC(16'h3000)) dut (
        .clk(clk), .rst(rst), .pcmux(pcmux), .target_pc(target_pc), .trap_pc(trap_pc),
        .br_stall(br_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_r(imem_r), .imem_data(imem_data), .de_ready(de_ready), .de_v(de_v),
        .de_ir(de_ir), .de_npc(de_npc), .count(count), .full(full),
        .perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_flush(perf_flush)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r_rst, input logic [1:0] mux, input logic [15:0] tpc,
                         input logic [15:0] vpc, input logic stall, input logic mr,
                         input logic [15:0] data, input logic dr);
        rst = r_rst; pcmux = mux; target_pc = tpc; trap_pc = vpc;
        br_stall = stall; imem_r = mr; imem_data = data; de_ready = dr;
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  pcmux;
        logic [15:0] tpc;
        logic [15:0] vpc;
        logic        stall;
        logic        r;
        logic [15:0] data;
        logic        dr;
        logic [2:0]  e_count;
        logic        e_full;
        logic        e_dev;
        logic [15:0] e_ir;
        logic [15:0] e_npc;
        logic [15:0] e_addr;
        logic        e_req;
    } vec_t;

    vec_t vt[20];

    typedef struct {
        logic [15:0] npc;
        logic [15:0] ir;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] mpc;
    int          m_fetched, m_stall, m_flush;

    initial begin
        // Expected values are the state after the edge, inputs still applied.
        vt[0]  = '{1, 0, 0, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h0000, 16'h0000, 16'h3000, 0};
        vt[1]  = '{0, 0, 0, 0, 0, 1, 16'h3000, 0,  1, 0, 1, 16'h3000, 16'h3002, 16'h3002, 1};
        vt[2]  = '{0, 0, 0, 0, 0, 1, 16'h3002, 0,  2, 0, 1, 16'h3000, 16'h3002, 16'h3004, 1};
        vt[3]  = '{0, 0, 0, 0, 0, 1, 16'h3004, 0,  3, 0, 1, 16'h3000, 16'h3002, 16'h3006, 1};
        vt[4]  = '{0, 0, 0, 0, 0, 1, 16'h3006, 0,  4, 1, 1, 16'h3000, 16'h3002, 16'h3008, 0};
        vt[5]  = '{0, 0, 0, 0, 0, 1, 16'h3008, 0,  4, 1, 1, 16'h3000, 16'h3002, 16'h3008, 0};
        vt[6]  = '{0, 0, 0, 0, 0, 0, 16'h0000, 1,  3, 0, 1, 16'h3002, 16'h3004, 16'h3008, 1};
        vt[7]  = '{0, 0, 0, 0, 0, 0, 16'h0000, 1,  2, 0, 1, 16'h3004, 16'h3006, 16'h3008, 1};
        vt[8]  = '{0, 0, 0, 0, 0, 0, 16'h0000, 1,  1, 0, 1, 16'h3006, 16'h3008, 16'h3008, 1};
        vt[9]  = '{0, 0, 0, 0, 0, 0, 16'h0000, 1,  0, 0, 0, 16'h0000, 16'h0000, 16'h3008, 1};
        vt[10] = '{0, 0, 0, 0, 0, 1, 16'h3008, 0,  1, 0, 1, 16'h3008, 16'h300A, 16'h300A, 1};
        vt[11] = '{0, 0, 0, 0, 0, 1, 16'h300A, 0,  2, 0, 1, 16'h3008, 16'h300A, 16'h300C, 1};
        vt[12] = '{0, 0, 0, 0, 0, 1, 16'h300C, 0,  3, 0, 1, 16'h3008, 16'h300A, 16'h300E, 1};
        vt[13] = '{0, 1, 16'h4000, 0, 0, 1, 16'h300E, 1,  0, 0, 0, 16'h0000, 16'h0000, 16'h4000, 0};
        vt[14] = '{0, 0, 0, 0, 0, 1, 16'hBEEF, 0,  1, 0, 1, 16'hBEEF, 16'h4002, 16'h4002, 1};
        vt[15] = '{0, 2, 0, 16'h0200, 0, 1, 16'h1234, 1,  0, 0, 0, 16'h0000, 16'h0000, 16'h0200, 0};
        vt[16] = '{0, 3, 0, 0, 0, 1, 16'h0200, 0,  1, 0, 1, 16'h0200, 16'h0202, 16'h0202, 1};
        vt[17] = '{0, 1, 16'hFFFE, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h0000, 16'h0000, 16'hFFFE, 0};
        vt[18] = '{0, 0, 0, 0, 0, 1, 16'h7777, 0,  1, 0, 1, 16'h7777, 16'h0000, 16'h0000, 1};
        vt[19] = '{1, 0, 0, 0, 0, 1, 16'h1111, 1,  0, 0, 0, 16'h0000, 16'h0000, 16'h3000, 0};

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].rst, vt[i].pcmux, vt[i].tpc, vt[i].vpc, vt[i].stall,
                  vt[i].r, vt[i].data, vt[i].dr);
            @(posedge clk); #1;
            check($sformatf("vec%0d count", i), 32'(count), 32'(vt[i].e_count));
            check($sformatf("vec%0d full", i), 32'(full), 32'(vt[i].e_full));
            check($sformatf("vec%0d de_v", i), 32'(de_v), 32'(vt[i].e_dev));
            check($sformatf("vec%0d de_ir", i), 32'(de_ir), 32'(vt[i].e_ir));
            check($sformatf("vec%0d de_npc", i), 32'(de_npc), 32'(vt[i].e_npc));
            check($sformatf("vec%0d imem_addr", i), 32'(imem_addr), 32'(vt[i].e_addr));
            check($sformatf("vec%0d imem_req", i), 32'(imem_req), 32'(vt[i].e_req));
        end

        // Branch stall with two queued entries: fetch frozen, queue drains.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 1, 16'h3000, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 1, 16'h3002, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 1, 1, 16'hAAAA, 1);
        #1;
        check("stall0 imem_req", 32'(imem_req), 32'd0);
        check("stall0 de_ir", 32'(de_ir), 32'h3000);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d imem_req", k), 32'(imem_req), 32'd0);
            check($sformatf("stall%0d imem_addr", k), 32'(imem_addr), 32'h3004);
            check($sformatf("stall%0d de_v", k), 32'(de_v), (k < 2) ? 32'd1 : 32'd0);
            if (k == 1) check("stall1 de_ir", 32'(de_ir), 32'h3002);
        end

        // Random traffic against the queue model.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        mq.delete(); mpc = 16'h3000;
        m_fetched = 0; m_stall = 0; m_flush = 0;
        for (int c = 0; c < 3000; c++) begin
            int          sz;
            int          sel;
            logic [1:0]  eff;
            logic        e_req, e_dev;
            logic [15:0] e_ir, e_npc;
            sel = int'($urandom_range(0, 15));
            drive(($urandom_range(0, 99) == 0),
                  (sel == 0) ? 2'b01 : (sel == 1) ? 2'b10 : (sel == 2) ? 2'b11 : 2'b00,
                  16'($urandom), 16'($urandom), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom_range(0, 1)));
            #1;
            sz    = mq.size();
            eff   = (pcmux == 2'b11) ? 2'b00 : pcmux;
            e_req = !rst && sz < DEPTH && !br_stall && eff == 2'b00;
            e_dev = !rst && sz != 0 && eff == 2'b00;
            e_ir  = e_dev || (!rst && sz != 0) ? mq[0].ir  : 16'h0000;
            e_npc = e_dev || (!rst && sz != 0) ? mq[0].npc : 16'h0000;
            check("rnd count", 32'(count), 32'(sz));
            check("rnd full", 32'(full), 32'(sz == DEPTH));
            check("rnd de_v", 32'(de_v), 32'(e_dev));
            check("rnd de_ir", 32'(de_ir), 32'(e_ir));
            check("rnd de_npc", 32'(de_npc), 32'(e_npc));
            check("rnd imem_addr", 32'(imem_addr), 32'(mpc));
            check("rnd imem_req", 32'(imem_req), 32'(e_req));
`ifdef FETCH_PERF_CNT_EN
            check("rnd perf_fetched", 32'(perf_fetched), 32'(m_fetched));
            check("rnd perf_stall", 32'(perf_stall), 32'(m_stall));
            check("rnd perf_flush", 32'(perf_flush), 32'(m_flush));
`else
            check("rnd perf_fetched", 32'(perf_fetched), 32'd0);
            check("rnd perf_stall", 32'(perf_stall), 32'd0);
            check("rnd perf_flush", 32'(perf_flush), 32'd0);
`endif
            @(posedge clk);
            if (rst) begin
                mq.delete(); mpc = 16'h3000;
                m_fetched = 0; m_stall = 0; m_flush = 0;
            end else if (eff != 2'b00) begin
                mq.delete();
                mpc = (eff == 2'b01) ? target_pc : trap_pc;
                if (de_ready) m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
                m_flush = (m_flush < 65535) ? m_flush + 1 : m_flush;
            end else begin
                if (de_ready && !e_dev) m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
                if (e_dev && de_ready) void'(mq.pop_front());
                if (e_req && imem_r) begin
                    mq.push_back('{npc: mpc + 16'd2, ir: imem_data});
                    mpc = mpc + 16'd2;
                    m_fetched = (m_fetched < 65535) ? m_fetched + 1 : m_fetched;
                end
            end
            #1;
        end

`ifdef FETCH_PERF_CNT_EN
        // Long decode starvation drives the stall counter into saturation.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 1, 0, 0, 1);
        repeat (70000) @(posedge clk);
        #1;
        check("perf_stall saturated", 32'(perf_stall), 32'h0000FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, at least 2.
REQ-002 Parameter WIDTH, default 16, instruction and address width in bits.
REQ-003 Parameter RESET_PC, default 16'h3000, fetch PC loaded on reset.
REQ-004 Ports: clk input 1, single clock; all state updates on its rising edge.
REQ-005 Ports: rst input 1, reset; synchronous and active-high.
REQ-006 Ports: pcmux input 2, redirect select: 00 sequential, 01 target, 10 trap, 11 reserved (treated as 00).
REQ-007 Ports: target_pc input WIDTH, branch/jump target address; trap_pc input WIDTH, trap vector address.
REQ-008 Ports: br_stall input 1, OR of the DE/AGEX/MEM branch stalls; blocks new fetch requests.
REQ-009 Ports: imem_req output 1, fetch request; imem_addr output WIDTH, fetch byte address.
REQ-010 Ports: imem_r input 1, memory ready/data valid; imem_data input WIDTH, fetched instruction.
REQ-011 Ports: de_ready input 1, decode accepts the head entry this cycle (not dep/mem stalled).
REQ-012 Ports: de_v output 1, de_ir output WIDTH, de_npc output WIDTH; these are the head entry.
REQ-013 Ports: count output clog2(DEPTH)+1 (occupancy); full output 1.
REQ-014 Ports: perf_fetched, perf_stall and perf_flush, each an output of 16 bits (see REQ-028).

Function
REQ-015 imem_req SHALL be 1 exactly when: not full, br_stall=0, effective pcmux=00 and rst=0.
REQ-016 imem_addr SHALL equal the fetch PC register at all times.
REQ-017 The memory request is accepted when imem_req=1 and imem_r=1 in the same cycle. On acceptance:
- {npc=fetch_pc+2, ir=imem_data} is enqueued.
- fetch_pc <= fetch_pc+2, modulo 2^WIDTH; 16'hFFFE wraps to 0000.
REQ-018 While imem_r=0 with imem_req=1, imem_addr SHALL hold steady and nothing is enqueued.
REQ-019 Dequeue occurs when de_v=1 and de_ready=1; the head advances on the next edge.
REQ-020 Outputs from head and queue state:
- de_v = (count!=0) and (effective pcmux==00).
- de_ir and de_npc = head entry when count!=0, else 0.
REQ-021 full = (count==DEPTH). While full, no enqueue occurs even if a dequeue happens in the same cycle.
REQ-022 With a simultaneous enqueue and dequeue (count not full, not empty), count is unchanged and both pointers advance.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 Redirect (pcmux 01/10) SHALL take priority over everything:
- On the next edge, count=0 and pointers=0.
- fetch_pc <= target_pc (01) or trap_pc (10).
- Any data arriving with imem_r in that cycle is discarded.
- Any dequeue in that cycle is void.
REQ-025 br_stall=1 SHALL hold fetch_pc. The queue continues to drain to decode.
REQ-026 Latency: an instruction accepted at edge N is visible on de_ir after edge N, with de_v=1 in cycle N+1.

Reset
REQ-027 While rst=1, on each edge:
- fetch_pc=RESET_PC, count=0, pointers=0.
- de_v=0, imem_req=0, de_ir=0, de_npc=0.
- perf counters=0.
- Reset mid-fetch or mid-redirect discards everything.

Configuration
REQ-028 Performance counters are controlled by macro FETCH_PERF_CNT_EN.
- When defined: 16-bit saturating counters (stick at FFFF).
- perf_fetched increments per enqueue.
- perf_stall increments per cycle with de_ready=1 and de_v=0.
- perf_flush increments per redirect cycle.
- When undefined: the three ports exist and are tied to 0, with no counter flops.

Structure
REQ-029 Shared package lc3b_fetch_pkg SHALL hold:
- PCMUX_SEQ/PCMUX_TARGET/PCMUX_TRAP encodings.
- Default RESET_PC 16'h3000.
- The queue entry type {npc, ir}.
REQ-030 Storage SHALL be a sub-module fetch_fifo: synchronous FIFO, parameters DEPTH and width 2*WIDTH, with a flush input. Fetch-PC and request logic stay in prefetch_queue.

Verification
REQ-031 Fill (DEPTH=4, imem_r=1, imem_data=imem_addr, de_ready=0) after reset:
- imem_addr runs 3000, 3002, 3004, 3006.
- Then full=1, count=4, imem_req=0, imem_addr=3008 held.
REQ-032 Drain from that state with de_ready=1:
- de_ir = 3000, 3002, 3004, 3006 on consecutive cycles.
- de_npc = 3002, 3004, 3006, 3008.
- Fetching resumes at 3008.
REQ-033 Target redirect (pcmux=01, target_pc=4000) with count=3:
- Next cycle: count=0, de_v=0, imem_addr=4000.
- First delivered entry: ir=mem[4000], npc=4002.
REQ-034 Trap redirect (pcmux=10, trap_pc=0200) in the same cycle as imem_r=1 at 3004:
- Data for 3004 never appears on de_ir.
- imem_addr=0200 next cycle.
REQ-035 br_stall=1 for 5 cycles with count=2, de_ready=1:
- imem_req=0 throughout, fetch_pc unchanged.
- Both entries are delivered, then de_v=0.
REQ-036 With FETCH_PERF_CNT_EN, run REQ-031 through REQ-034:
- perf_fetched counts every enqueue.
- perf_flush=2.
- Forcing 70000 stall cycles leaves perf_stall=FFFF.
